// File: rtl/map_port_arbiter.sv
// -----------------------------------------------------------------------------
// map_port_arbiter
//   Shares the single read port of the 128x128 world-map memory between the
//   VGA scaler (fixed-latency stream, strict priority) and the Rojobot
//   (req/ack handshake). A one-entry VGA address cache absorbs repeated
//   scaled addresses so neighbouring pixels of one map cell leave the memory
//   slot free for the bot.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   vid_req, vid_addr    VGA pixel request and scaled {row,col} address
//   vid_valid, vid_data  VGA result, MEM_LAT+2 cycles after its vid_req
//   bot_req, bot_addr    bot level request, held until bot_ack
//   bot_ack, bot_data    one-cycle acknowledge with the map cell
//   map_inval            one-cycle pulse, map contents changed
//   mem_rd_en, mem_addr  registered read strobe/address to the map memory
//   mem_data             read data, MEM_LAT cycles after mem_rd_en
//   bot_starve           bot waited >= STARVE_LIM cycles, sticky until ack
// -----------------------------------------------------------------------------
module map_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 2,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  input  logic              bot_req,
  input  logic [ADDR_W-1:0] bot_addr,
  output logic              bot_ack,
  output logic [DATA_W-1:0] bot_data,
  input  logic              map_inval,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              bot_starve
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    ACK
  } bot_state_t;

  localparam logic [1:0] LAT_M = 2'(MEM_LAT);
  localparam logic [7:0] LIM   = 8'(STARVE_LIM);

  bot_state_t        state, state_next;

  logic [ADDR_W-1:0] tag;
  logic              tag_valid;
  logic [DATA_W-1:0] cache_data;

  // VGA slot pipeline: one {valid,hit} pair per cycle of memory latency.
  logic [MEM_LAT:0]  pipe_valid;
  logic [MEM_LAT:0]  pipe_hit;

  logic [1:0]        wait_cnt;
  logic [7:0]        starve_cnt, starve_cnt_next;

  logic              vid_hit, vid_miss;
  logic              bot_pending, bot_grant;

  // ---------------------------------------------------------------------------
  // Arbitration and bot next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_next      = state;
    starve_cnt_next = 8'd0;

    vid_hit  = tag_valid && (vid_addr == tag);
    vid_miss = vid_req && !vid_hit;

    // A request is arbitrated in the very cycle it is first seen, so an
    // uncontended request is granted straight out of IDLE.
    bot_pending = bot_req && ((state == IDLE) || (state == REQ));
    bot_grant   = bot_pending && !vid_miss;

    if (bot_pending && !bot_grant) begin
      starve_cnt_next = (starve_cnt == 8'hFF) ? starve_cnt : starve_cnt + 8'd1;
    end

    unique case (state)
      IDLE: if (bot_req) state_next = bot_grant ? WAIT : REQ;
      REQ: begin
        if (!bot_req)       state_next = IDLE;
        else if (bot_grant) state_next = WAIT;
      end
      WAIT: if (wait_cnt == LAT_M) state_next = ACK;
      ACK:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  assign bot_ack = (state == ACK);

  // ---------------------------------------------------------------------------
  // Memory port, VGA cache and pipeline, bot data path
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: cache_data is reset along with everything else; it is a single
      // register, not a memory array, and a known value simplifies debug.
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      tag        <= '0;
      tag_valid  <= 1'b0;
      cache_data <= '0;
      pipe_valid <= '0;
      pipe_hit   <= '0;
      vid_valid  <= 1'b0;
      vid_data   <= '0;
      bot_data   <= '0;
      wait_cnt   <= 2'd0;
      starve_cnt <= 8'd0;
      bot_starve <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      mem_rd_en <= vid_miss || bot_grant;
      if (vid_miss)       mem_addr <= vid_addr;
      else if (bot_grant) mem_addr <= bot_addr;

      if (vid_miss) tag <= vid_addr;
      // An invalidate wins over a same-cycle miss fill.
      if (map_inval)     tag_valid <= 1'b0;
      else if (vid_miss) tag_valid <= 1'b1;

      pipe_valid <= {pipe_valid[MEM_LAT-1:0], vid_req};
      pipe_hit   <= {pipe_hit[MEM_LAT-1:0], vid_hit};

      // Reads complete in order, so a hit always follows the miss that filled
      // cache_data through this stage.
      vid_valid <= pipe_valid[MEM_LAT];
      if (pipe_valid[MEM_LAT]) begin
        if (pipe_hit[MEM_LAT]) begin
          vid_data <= cache_data;
        end else begin
          vid_data   <= mem_data;
          cache_data <= mem_data;
        end
      end

      if (bot_grant)          wait_cnt <= 2'd0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 2'd1;

      if ((state == WAIT) && (wait_cnt == LAT_M)) bot_data <= mem_data;

      starve_cnt <= starve_cnt_next;
      // Starvation flag survives the grant and clears with the ack, or when
      // the bot withdraws its request while still waiting for a slot.
      if ((state_next == ACK) || ((state == REQ) && (state_next == IDLE)))
        bot_starve <= 1'b0;
      else if (starve_cnt_next >= LIM)
        bot_starve <= 1'b1;
    end
  end

endmodule
